batch_mean_seq: RTL and testbench

//  Sequential, multi-channel batch-mean unit for the batch-normalization datapath.
//  - Accepts a batch of 1..MAX_N signed fixed-point samples per channel over a valid/ready stream.
//  - Accumulates each channel at full precision.
//  - Divides every channel sum by the batch count using one shared-timing iterative divider per channel.
//  - Presents the CH means on a valid/ready output.
//  - Feeds the variance and normalize stages downstream.

---
 rtl/bn_pkg.sv | 16 +
 rtl/mean_div.sv | 41 ++++
 rtl/batch_mean_seq.sv | 135 +++++++++++++
 tb/tb_batch_mean_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bn_pkg.sv
// Shared types and defaults for the batch-normalization datapath.
package bn_pkg;

    localparam int IL_DEF = 4;
    localparam int FL_DEF = 16;

    typedef logic signed [IL_DEF+FL_DEF-1:0] fx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mean_state_t;

endpackage

// File: rtl/mean_div.sv
// Unsigned restoring divider, one quotient bit per step; sequencing comes from the caller.
module mean_div #(
    parameter int AW = 25,
    parameter int NW = 5,
    parameter int QW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [AW-1:0] i_dividend,
    input  logic [NW-1:0] i_divisor,
    output logic [QW-1:0] o_quot_next
);

    logic [NW-1:0] r_rem;
    logic [AW-1:0] r_quo;
    logic [NW:0]   w_trial;
    logic [NW:0]   w_diff;
    logic          w_fit;

    // Dividend bits shift out of the top of r_quo while quotient bits shift in below.
    assign w_trial     = {r_rem, r_quo[AW-1]};
    assign w_fit       = (w_trial >= {1'b0, i_divisor});
    assign w_diff      = w_trial - {1'b0, i_divisor};
    assign o_quot_next = {r_quo[QW-2:0], w_fit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
        end else if (i_step) begin
            r_rem <= w_fit ? w_diff[NW-1:0] : w_trial[NW-1:0];
            r_quo <= {r_quo[AW-2:0], w_fit};
        end
    end

endmodule

// File: rtl/batch_mean_seq.sv
// Multi-channel batch mean: accumulate num signed samples per channel, then divide by num.
module batch_mean_seq
    import bn_pkg::*;
#(
    parameter int  IL    = IL_DEF,
    parameter int  FL    = FL_DEF,
    parameter int  CH    = 4,
    parameter int  MAX_N = 16,
    localparam int W     = IL + FL,
    localparam int NW    = $clog2(MAX_N + 1),
    localparam int AW    = W + NW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NW-1:0]       num,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH-1:0][W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH-1:0][W-1:0] out_mean,
    output logic                busy,
    output logic                err
);

    localparam int BW = $clog2(AW);

    mean_state_t            r_state;
    logic [NW-1:0]          r_num;
    logic [NW-1:0]          r_cnt;
    logic [BW-1:0]          r_bit;
    logic                   r_err;
    logic [CH-1:0][W-1:0]   r_mean;

    logic w_start_ok;
    logic w_hs;
    logic w_last;
    logic w_div;
    logic w_div_end;

    assign w_start_ok = start && (num >= NW'(1)) && (num <= NW'(MAX_N));
    assign w_hs       = in_valid && (r_state == ACC) && !start;
    assign w_last     = w_hs && ((r_cnt + NW'(1)) == r_num);
    assign w_div      = (r_state == DIV);
    assign w_div_end  = w_div && (r_bit == BW'(AW - 1));

    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign err       = r_err;
    assign out_mean  = r_mean;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_num   <= '0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= start && !w_start_ok;
            if (start) begin
                if (w_start_ok) begin
                    r_state <= ACC;
                    r_num   <= num;
                    r_cnt   <= '0;
                end else begin
                    r_state <= IDLE;
                end
            end else begin
                case (r_state)
                    ACC: begin
                        if (w_hs) begin
                            r_cnt <= r_cnt + NW'(1);
                            if (w_last) begin
                                r_state <= DIV;
                                r_bit   <= '0;
                            end
                        end
                    end
                    DIV: begin
                        if (w_div_end) r_state <= DONE;
                        else           r_bit   <= r_bit + BW'(1);
                    end
                    DONE: begin
                        if (out_ready) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [AW-1:0] r_acc;
        logic [AW-1:0] w_sext;
        logic [AW-1:0] w_acc_next;
        logic [AW-1:0] w_abs;
        logic [W-1:0]  w_quot;
        logic [W-1:0]  w_mean;

        assign w_sext     = {{NW{in_data[c][W-1]}}, in_data[c]};
        assign w_acc_next = r_acc + w_sext;
        // The divider loads from the post-add sum so DIV starts on the very next cycle.
        assign w_abs      = w_acc_next[AW-1] ? (-w_acc_next) : w_acc_next;
        assign w_mean     = r_acc[AW-1] ? (-w_quot) : w_quot;

        mean_div #(
            .AW(AW),
            .NW(NW),
            .QW(W)
        ) u_div (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_last),
            .i_step     (w_div),
            .i_dividend (w_abs),
            .i_divisor  (r_num),
            .o_quot_next(w_quot)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc     <= '0;
                r_mean[c] <= '0;
            end else begin
                if (w_start_ok)     r_acc <= '0;
                else if (w_hs)      r_acc <= w_acc_next;
                if (w_div_end && !start) r_mean[c] <= w_mean;
            end
        end
    end

endmodule

// File: tb/tb_batch_mean_seq.sv
// Directed bench for batch_mean_seq with hand-computed means.
module tb_batch_mean_seq;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [4:0]        num;
    logic              in_valid;
    logic              in_ready;
    logic [3:0][19:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0][19:0]  out_mean;
    logic              busy;
    logic              err;

    int n_cmp  = 0;
    int n_fail = 0;

    batch_mean_seq #(.IL(4), .FL(16), .CH(4), .MAX_N(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num      (num),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mean (out_mean),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0][19:0] mk(input logic [19:0] a, input logic [19:0] b,
                                            input logic [19:0] c, input logic [19:0] d);
        logic [3:0][19:0] v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    task automatic chk_means(input string tag, input logic [3:0][19:0] exp);
        for (int c = 0; c < 4; c++)
            chk($sformatf("%s_ch%0d", tag, c), 80'(out_mean[c]), 80'(exp[c]));
    endtask

    task automatic do_start(input logic [4:0] n);
        start = 1'b1;
        num   = n;
        tick();
        start = 1'b0;
        num   = '0;
    endtask

    task automatic send(input logic [3:0][19:0] d);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        chk("send_in_ready", 80'(in_ready), 80'(1));
        tick();
        in_valid = 1'b0;
        in_data  = mk(20'h5A5A5, 20'hA5A5A, 20'h33333, 20'hCCCCC);
    endtask

    task automatic wait_out(output int cyc, output logic saw_ready);
        cyc       = 0;
        saw_ready = 1'b0;
        while (!out_valid && cyc < 100) begin
            saw_ready = saw_ready | in_ready;
            tick();
            cyc++;
        end
        chk("out_valid_arrives", 80'(out_valid), 80'(1));
    endtask

    task automatic accept;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drops", 80'(out_valid), 80'(0));
    endtask

    int               cyc;
    logic             saw;
    logic             stable;
    logic             vheld;
    logic [3:0][19:0] snap;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_busy",      80'(busy),      80'(0));
        chk("rst_in_ready",  80'(in_ready),  80'(0));
        chk("rst_out_valid", 80'(out_valid), 80'(0));
        chk("rst_err",       80'(err),       80'(0));
        chk("rst_out_mean",  80'(out_mean),  80'(0));
        #14 rst_n = 1'b1;
        tick();

        // 1: num=4, basic mean and latency
        do_start(5'd4);
        chk("t1_busy",     80'(busy),     80'(1));
        chk("t1_in_ready", 80'(in_ready), 80'(1));
        send(mk(20'h10000, 20'hF8000, 20'h00003, 20'h7FFFF));
        send(mk(20'h20000, 20'hF8000, 20'h00003, 20'h00000));
        send(mk(20'h30000, 20'hF8000, 20'h00003, 20'h00000));
        send(mk(20'h40000, 20'hF8000, 20'h00003, 20'h00000));
        wait_out(cyc, saw);
        chk("t1_latency", 80'(cyc + 1), 80'(26));
        chk("t1_no_ready_in_div", 80'(saw), 80'(0));
        chk_means("t1_mean", mk(20'h28000, 20'hF8000, 20'h00003, 20'h1FFFF));
        accept();
        chk("t1_idle_busy", 80'(busy), 80'(0));

        // 2: truncation toward zero
        do_start(5'd3);
        send(mk(20'h00001, 20'hFFFFB, 20'h00002, 20'hF8000));
        send(mk(20'h00000, 20'h00000, 20'h00002, 20'hF8000));
        send(mk(20'h00000, 20'h00000, 20'h00002, 20'hF8000));
        wait_out(cyc, saw);
        chk_means("t2_mean", mk(20'h00000, 20'hFFFFF, 20'h00002, 20'hF8000));
        accept();

        // 3: full batch at both extremes
        do_start(5'd16);
        for (int i = 0; i < 16; i++) send(mk(20'h80000, 20'h80000, 20'h80000, 20'h80000));
        wait_out(cyc, saw);
        chk_means("t3_min", mk(20'h80000, 20'h80000, 20'h80000, 20'h80000));
        accept();
        do_start(5'd16);
        for (int i = 0; i < 16; i++) send(mk(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF));
        wait_out(cyc, saw);
        chk_means("t3_max", mk(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF));
        accept();

        // 4: gappy input, surplus valid, stalled output
        do_start(5'd5);
        for (int i = 1; i <= 5; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int k = 0; k < gap; k++) begin
                in_valid = 1'b0;
                in_data  = 20'($urandom) * 80'h1;
                tick();
            end
            send(mk(20'(i * 32'h10000), 20'(-i), 20'(i * 7), 20'h10000));
        end
        in_valid = 1'b1;
        in_data  = mk(20'h11111, 20'h11111, 20'h11111, 20'h11111);
        wait_out(cyc, saw);
        chk("t4_no_ready_in_div", 80'(saw), 80'(0));
        snap   = out_mean;
        stable = 1'b1;
        vheld  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            stable = stable & (out_mean === snap);
            vheld  = vheld & out_valid & !in_ready;
        end
        chk("t4_mean_stable", 80'(stable), 80'(1));
        chk("t4_valid_held",  80'(vheld),  80'(1));
        in_valid = 1'b0;
        chk_means("t4_mean", mk(20'h30000, 20'hFFFFD, 20'h00015, 20'h10000));
        accept();

        // 5: illegal num, then abort mid-batch
        do_start(5'd0);
        chk("t5_err_n0",  80'(err),  80'(1));
        chk("t5_busy_n0", 80'(busy), 80'(0));
        tick();
        chk("t5_err_pulse", 80'(err), 80'(0));
        do_start(5'd17);
        chk("t5_err_n17",  80'(err),  80'(1));
        chk("t5_busy_n17", 80'(busy), 80'(0));
        tick();
        do_start(5'd4);
        send(mk(20'h70000, 20'h70000, 20'h70000, 20'h70000));
        send(mk(20'h70000, 20'h70000, 20'h70000, 20'h70000));
        do_start(5'd2);
        chk("t5_restart_ready", 80'(in_ready), 80'(1));
        chk("t5_restart_err",   80'(err),      80'(0));
        send(mk(20'h10000, 20'hFFFFE, 20'h00005, 20'h80000));
        send(mk(20'h30000, 20'hFFFFE, 20'h00002, 20'h80000));
        wait_out(cyc, saw);
        chk_means("t5_mean", mk(20'h20000, 20'hFFFFE, 20'h00003, 20'h80000));
        accept();

        // 6: async reset in DIV, recovery, start coinciding with DONE handshake
        do_start(5'd2);
        send(mk(20'h12345, 20'h12345, 20'h12345, 20'h12345));
        send(mk(20'h12345, 20'h12345, 20'h12345, 20'h12345));
        for (int k = 0; k < 5; k++) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy",      80'(busy),      80'(0));
        chk("t6_rst_in_ready",  80'(in_ready),  80'(0));
        chk("t6_rst_out_valid", 80'(out_valid), 80'(0));
        chk("t6_rst_out_mean",  80'(out_mean),  80'(0));
        #12 rst_n = 1'b1;
        tick();
        do_start(5'd1);
        send(mk(20'h12345, 20'h80000, 20'h7FFFF, 20'hFEDCB));
        wait_out(cyc, saw);
        chk_means("t6_n1", mk(20'h12345, 20'h80000, 20'h7FFFF, 20'hFEDCB));
        out_ready = 1'b1;
        start     = 1'b1;
        num       = 5'd1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("t6_b2b_out_valid", 80'(out_valid), 80'(0));
        chk("t6_b2b_in_ready",  80'(in_ready),  80'(1));
        send(mk(20'hFFFFF, 20'h00001, 20'h54321, 20'hABCDE));
        wait_out(cyc, saw);
        chk_means("t6_b2b", mk(20'hFFFFF, 20'h00001, 20'h54321, 20'hABCDE));
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
